shift_arbiter: RTL

- Shares one `shifter` datapath instance between two requesters (port 0 and port 1).
- Handles valid/ready handshakes on each side, round-robin arbitration and a single registered result stage.
- Sits between the ALU-side issue logic and the consumer of shift results, typically the writeback mux.
- Also keeps saturating per-port completion counters for performance monitoring.

---
 rtl/shift_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Two-port round-robin front end sharing a single shifter, with a one-entry
// registered result stage and saturating per-port completion counters.

module shifter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [4:0]            b,
    input  logic [1:0]            op,
    output logic [DATA_WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            2'b00:   y = a << b;
            2'b10:   y = a >> b;
            2'b11:   y = $signed(a) >>> b;
            default: y = '0;
        endcase
    end
endmodule

module shift_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_A,
    input  logic [4:0]            req0_B,
    input  logic [1:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_A,
    input  logic [4:0]            req1_B,
    input  logic [1:0]            req1_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_id,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                state, state_next;
    logic                  rr;
    logic                  grant;
    logic                  can_accept;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [4:0]            sel_b;
    logic [1:0]            sel_op;
    logic [DATA_WIDTH-1:0] shift_y;
    logic                  rsp_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // Grant depends only on the request valids and rr, never on rsp_ready.
    always_comb begin
        grant      = 1'b0;
        can_accept = (state == EMPTY) | rsp_ready;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = (state == FULL);
        state_next = state;

        if (req0_valid && req1_valid) grant = rr;
        else if (req1_valid)          grant = 1'b1;

        req0_ready = can_accept & ~grant;
        req1_ready = can_accept & grant;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

        if (accept)         state_next = FULL;
        else if (rsp_ready) state_next = EMPTY;
    end

    assign sel_a    = grant ? req1_A  : req0_A;
    assign sel_b    = grant ? req1_B  : req0_B;
    assign sel_op   = grant ? req1_op : req0_op;
    assign rsp_fire = rsp_valid & rsp_ready;

    shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
        .a  (sel_a),
        .b  (sel_b),
        .op (sel_op),
        .y  (shift_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            rr       <= 1'b0;
        end else if (accept) begin
            rsp_data <= shift_y;
            rsp_id   <= grant;
            rr       <= ~grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_fire) begin
            if (!rsp_id && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
            if (rsp_id && cnt1 != '1)  cnt1 <= cnt1 + 1'b1;
        end
    end
endmodule
